branch_pc_unit: RTL and testbench



---
 rtl/cpu_pkg.sv | 15 +
 rtl/branch_pc_unit_if.sv | 30 +++
 rtl/ret_addr_stack.sv | 49 ++++
 rtl/branch_pc_unit.sv | 100 ++++++++++
 tb/tb_branch_pc_unit.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Opcode encodings shared by decode, the branch/PC unit and the other ALUs.
// Pure definitions: no logic, no latency, no flow control.
package cpu_pkg;

   typedef logic [5:0] opcode_t;

   localparam opcode_t OP_BEQ  = 6'b001000;
   localparam opcode_t OP_BNE  = 6'b001001;
   localparam opcode_t OP_JR   = 6'b001010;
   localparam opcode_t OP_BEQZ = 6'b001011;
   localparam opcode_t OP_BENZ = 6'b001100;
   localparam opcode_t OP_JAL  = 6'b001101;
   localparam opcode_t OP_RET  = 6'b001110;

endpackage

// File: rtl/branch_pc_unit_if.sv
// Decode-to-fetch bundle: resolved-instruction inputs and PC/status outputs.
// master = decode side driving operands, slave = branch_pc_unit.
interface branch_pc_unit_if
   import cpu_pkg::*;
#(
   parameter int DW = 8,
   parameter int AW = 8
);
   logic          valid_i;
   logic          stall_i;
   opcode_t       opcode;
   logic [DW-1:0] x;
   logic [DW-1:0] y;
   logic [AW-1:0] offset;
   logic [AW-1:0] pc_o;
   logic          taken_o;
   logic          ras_ovf_o;
   logic          ras_unf_o;

   modport master (
      output valid_i, stall_i, opcode, x, y, offset,
      input  pc_o, taken_o, ras_ovf_o, ras_unf_o
   );

   modport slave (
      input  valid_i, stall_i, opcode, x, y, offset,
      output pc_o, taken_o, ras_ovf_o, ras_unf_o
   );

endinterface

// File: rtl/ret_addr_stack.sv
// Circular return-address LIFO; push/pop take effect on the clock edge, pop_data is the current top.
// No backpressure: a push when full overwrites the oldest entry and pulses ovf.
module ret_addr_stack #(
   parameter int AW        = 8,
   parameter int RAS_DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic          pop,
   input  logic [AW-1:0] push_data,
   output logic [AW-1:0] pop_data,
   output logic          empty,
   output logic          full,
   output logic          ovf
);
   localparam int            PW      = $clog2(RAS_DEPTH);
   localparam logic [PW-1:0] PTR_ONE = PW'(1);
   localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);
   localparam logic [PW:0]   CNT_MAX = (PW+1)'(RAS_DEPTH);

   logic [AW-1:0] mem [RAS_DEPTH];
   logic [PW-1:0] ptr;
   logic [PW-1:0] top_idx;
   logic [PW:0]   count;

   // ptr is the next write slot, so the newest entry sits one below it
   assign top_idx  = ptr - PTR_ONE;
   assign pop_data = mem[top_idx];
   assign empty    = (count == '0);
   assign full     = (count == CNT_MAX);
   assign ovf      = push & full;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr   <= '0;
         count <= '0;
         for (int i = 0; i < RAS_DEPTH; i++) mem[i] <= '0;
      end else if (push) begin
         mem[ptr] <= push_data;
         ptr      <= ptr + PTR_ONE;
         if (!full) count <= count + CNT_ONE;
      end else if (pop && !empty) begin
         ptr   <= top_idx;
         count <= count - CNT_ONE;
      end
   end

endmodule

// File: rtl/branch_pc_unit.sv
// Owns the PC and resolves branches, jumps and call/return; new PC visible 1 cycle after resolve.
// stall_i freezes PC, RAS and flags (taken_o forced low); otherwise one instruction per cycle.
module branch_pc_unit
   import cpu_pkg::*;
#(
   parameter int          DW        = 8,
   parameter int          AW        = 8,
   parameter int          RAS_DEPTH = 4,
   parameter int unsigned RESET_PC  = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   branch_pc_unit_if.slave  bus
);
   localparam logic [AW-1:0] RST_PC = AW'(RESET_PC);
   localparam logic [AW-1:0] PC_ONE = AW'(1);

   logic [AW-1:0] pc, pc_inc, pc_rel, x_abs, next_pc, ras_top;
   logic          taken, ovf_flag, unf_flag;
   logic          take, push, pop, unf_evt, adv;
   logic          ras_empty, ras_ovf, unused_ras_full;

   generate
      if (DW >= AW) begin : g_x_trunc
         assign x_abs = bus.x[AW-1:0];
      end else begin : g_x_zext
         assign x_abs = {{(AW-DW){1'b0}}, bus.x};
      end
   endgenerate

   // Two's-complement offset: a plain modulo-2^AW add covers backward branches
   assign pc_inc = pc + PC_ONE;
   assign pc_rel = pc + bus.offset;
   assign adv    = bus.valid_i & ~bus.stall_i;

   always_comb begin
      next_pc = pc_inc;
      take    = 1'b0;
      push    = 1'b0;
      pop     = 1'b0;
      unf_evt = 1'b0;
      if (bus.valid_i) begin
         case (bus.opcode)
            OP_BEQ:  if (bus.x == bus.y) begin next_pc = pc_rel; take = 1'b1; end
            OP_BNE:  if (bus.x != bus.y) begin next_pc = pc_rel; take = 1'b1; end
            OP_JR:   begin next_pc = x_abs; take = 1'b1; end
            OP_BEQZ: if (bus.x == '0) begin next_pc = pc_rel; take = 1'b1; end
            OP_BENZ: if (bus.x != '0) begin next_pc = pc_rel; take = 1'b1; end
            OP_JAL:  begin next_pc = pc_rel; take = 1'b1; push = adv; end
            OP_RET: begin
               if (!ras_empty) begin
                  next_pc = ras_top;
                  take    = 1'b1;
                  pop     = adv;
               end else begin
                  unf_evt = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   ret_addr_stack #(
      .AW        (AW),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .pop       (pop),
      .push_data (pc_inc),
      .pop_data  (ras_top),
      .empty     (ras_empty),
      .full      (unused_ras_full),
      .ovf       (ras_ovf)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc       <= RST_PC;
         taken    <= 1'b0;
         ovf_flag <= 1'b0;
         unf_flag <= 1'b0;
      end else if (bus.stall_i) begin
         taken <= 1'b0;
      end else begin
         pc    <= next_pc;
         taken <= take;
         if (ras_ovf) ovf_flag <= 1'b1;
         if (unf_evt) unf_flag <= 1'b1;
      end
   end

   assign bus.pc_o      = pc;
   assign bus.taken_o   = taken;
   assign bus.ras_ovf_o = ovf_flag;
   assign bus.ras_unf_o = unf_flag;

endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed vector table, hand-written RAS/stall/reset sequences and a random run against a queue-based model.
module tb_branch_pc_unit;

   localparam logic [5:0] T_BEQ  = 6'b001000;
   localparam logic [5:0] T_BNE  = 6'b001001;
   localparam logic [5:0] T_JR   = 6'b001010;
   localparam logic [5:0] T_BEQZ = 6'b001011;
   localparam logic [5:0] T_BENZ = 6'b001100;
   localparam logic [5:0] T_JAL  = 6'b001101;
   localparam logic [5:0] T_RET  = 6'b001110;
   localparam int         DEPTH  = 4;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   branch_pc_unit_if #(.DW(8), .AW(8)) bus ();

   branch_pc_unit #(
      .DW        (8),
      .AW        (8),
      .RAS_DEPTH (DEPTH),
      .RESET_PC  (0)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks   = 0;
   int failures = 0;

   int m_pc;
   bit m_taken, m_ovf, m_unf;
   int ras[$];

   typedef struct {
      bit         v;
      bit         s;
      logic [5:0] op;
      int         x;
      int         y;
      int         off;
      int         epc;
      bit         etk;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int wrap(input int v);
      return ((v % 256) + 256) % 256;
   endfunction

   function automatic void model_reset();
      m_pc    = 0;
      m_taken = 0;
      m_ovf   = 0;
      m_unf   = 0;
      ras.delete();
   endfunction

   function automatic void model_step(input bit v, input bit s, input logic [5:0] op,
                                      input int xx, input int yy, input int off);
      int so;
      int npc;
      bit tk;
      if (s) begin
         m_taken = 0;
         return;
      end
      so  = (off >= 128) ? off - 256 : off;
      npc = wrap(m_pc + 1);
      tk  = 0;
      if (v) begin
         case (op)
            T_BEQ:  if (xx == yy) begin npc = wrap(m_pc + so); tk = 1; end
            T_BNE:  if (xx != yy) begin npc = wrap(m_pc + so); tk = 1; end
            T_JR:   begin npc = xx; tk = 1; end
            T_BEQZ: if (xx == 0) begin npc = wrap(m_pc + so); tk = 1; end
            T_BENZ: if (xx != 0) begin npc = wrap(m_pc + so); tk = 1; end
            T_JAL: begin
               ras.push_back(wrap(m_pc + 1));
               if (ras.size() > DEPTH) begin
                  void'(ras.pop_front());
                  m_ovf = 1;
               end
               npc = wrap(m_pc + so);
               tk  = 1;
            end
            T_RET: begin
               if (ras.size() > 0) begin
                  npc = ras.pop_back();
                  tk  = 1;
               end else begin
                  m_unf = 1;
               end
            end
            default: ;
         endcase
      end
      m_pc    = npc;
      m_taken = tk;
   endfunction

   task automatic step(input bit v, input bit s, input logic [5:0] op,
                       input int xx, input int yy, input int off);
      bus.valid_i = v;
      bus.stall_i = s;
      bus.opcode  = op;
      bus.x       = xx[7:0];
      bus.y       = yy[7:0];
      bus.offset  = off[7:0];
      @(posedge clk);
      #1;
      model_step(v, s, op, xx, yy, off);
      chk("model_pc", {24'd0, bus.pc_o}, m_pc);
      chk("model_taken", {31'd0, bus.taken_o}, {31'd0, m_taken});
      chk("model_ovf", {31'd0, bus.ras_ovf_o}, {31'd0, m_ovf});
      chk("model_unf", {31'd0, bus.ras_unf_o}, {31'd0, m_unf});
   endtask

   task automatic expect_out(input string name, input int pc, input bit tk);
      chk({name, "_pc"}, {24'd0, bus.pc_o}, pc);
      chk({name, "_taken"}, {31'd0, bus.taken_o}, {31'd0, tk});
   endtask

   initial begin
      rst_n       = 1'b0;
      bus.valid_i = 1'b0;
      bus.stall_i = 1'b0;
      bus.opcode  = '0;
      bus.x       = '0;
      bus.y       = '0;
      bus.offset  = '0;

      tbl.push_back('{0, 0, 6'h00,     0,   0,   0,   1, 0});
      tbl.push_back('{0, 0, 6'h00,     0,   0,   0,   2, 0});
      tbl.push_back('{0, 0, 6'h00,     0,   0,   0,   3, 0});
      tbl.push_back('{1, 0, T_JR,      5,   0,   0,   5, 1});
      tbl.push_back('{1, 0, T_BEQ,     7,   7,   4,   9, 1});
      tbl.push_back('{1, 0, T_JR,      5,   0,   0,   5, 1});
      tbl.push_back('{1, 0, T_BEQ,     7,   6,   4,   6, 0});
      tbl.push_back('{1, 0, T_JR,      5,   0,   0,   5, 1});
      tbl.push_back('{1, 0, T_BNE,     3,   3, 254,   6, 0});
      tbl.push_back('{1, 0, T_BENZ,    1,   0, 254,   4, 1});
      tbl.push_back('{1, 0, T_JR,    255,   0,   0, 255, 1});
      tbl.push_back('{1, 0, T_BEQZ,    1,   0,   9,   0, 0});
      tbl.push_back('{1, 0, T_JR,     64,   0,   0,  64, 1});
      tbl.push_back('{1, 0, T_BEQ,     2,   2,   0,  64, 1});
      tbl.push_back('{1, 0, 6'h3F,     0,   0,   7,  65, 0});
      tbl.push_back('{0, 0, T_BEQ,     1,   1,   7,  66, 0});
      tbl.push_back('{1, 0, T_BEQZ,    0,   0, 255,  65, 1});
      tbl.push_back('{1, 0, 6'h00,     0,   0,   3,  66, 0});
      tbl.push_back('{1, 0, T_BNE,     1,   2,  16,  82, 1});
      tbl.push_back('{1, 0, T_BENZ,    0,   0,   3,  83, 0});

      repeat (2) @(posedge clk);
      #1;
      expect_out("reset", 0, 0);
      chk("reset_ovf", {31'd0, bus.ras_ovf_o}, 0);
      chk("reset_unf", {31'd0, bus.ras_unf_o}, 0);
      rst_n = 1'b1;
      model_reset();

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].v, tbl[i].s, tbl[i].op, tbl[i].x, tbl[i].y, tbl[i].off);
         expect_out($sformatf("vec%0d", i), tbl[i].epc, tbl[i].etk);
      end

      // Five calls into a four-deep stack, then unwind past empty
      step(1, 0, T_JR, 10, 0, 0);
      expect_out("ras_start", 10, 1);
      for (int i = 0; i < 5; i++) begin
         step(1, 0, T_JAL, 0, 0, 10);
         expect_out($sformatf("jal%0d", i), 20 + 10 * i, 1);
         chk($sformatf("jal%0d_ovf", i), {31'd0, bus.ras_ovf_o}, (i == 4) ? 1 : 0);
      end
      for (int i = 0; i < 4; i++) begin
         step(1, 0, T_RET, 0, 0, 0);
         expect_out($sformatf("ret%0d", i), 51 - 10 * i, 1);
      end
      step(1, 0, T_RET, 0, 0, 0);
      expect_out("ret_empty", 22, 0);
      chk("ret_empty_unf", {31'd0, bus.ras_unf_o}, 1);

      // Stall freezes a taken branch until release
      step(1, 1, T_BEQ, 1, 1, 5);
      expect_out("stall1", 22, 0);
      step(1, 1, T_BEQ, 1, 1, 5);
      expect_out("stall2", 22, 0);
      step(1, 0, T_BEQ, 1, 1, 5);
      expect_out("stall_release", 27, 1);
      step(0, 0, 6'h00, 0, 0, 0);
      expect_out("taken_pulse_end", 28, 0);
      step(0, 1, 6'h00, 0, 0, 0);
      expect_out("stall_idle", 28, 0);
      step(1, 0, T_JAL, 0, 0, 2);
      expect_out("jal_pre_stall", 30, 1);
      step(1, 1, T_RET, 0, 0, 0);
      step(1, 1, T_RET, 0, 0, 0);
      expect_out("stall_ret", 30, 0);
      step(1, 0, T_RET, 0, 0, 0);
      expect_out("ret_release", 29, 1);
      step(1, 1, T_JAL, 0, 0, 5);
      expect_out("stall_jal", 29, 0);
      step(1, 0, T_RET, 0, 0, 0);
      expect_out("ret_after_stalled_jal", 30, 0);

      // Asynchronous reset between clock edges
      bus.valid_i = 1'b0;
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      expect_out("async_rst", 0, 0);
      chk("async_rst_ovf", {31'd0, bus.ras_ovf_o}, 0);
      chk("async_rst_unf", {31'd0, bus.ras_unf_o}, 0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      step(1, 0, T_BEQ, 4, 4, 3);
      expect_out("post_rst_beq", 3, 1);
      step(1, 0, T_RET, 0, 0, 0);
      expect_out("post_rst_ret", 4, 0);

      for (int i = 0; i < 3000; i++) begin
         bit         v, s;
         logic [5:0] op;
         int         xx, yy, off;
         v   = ($urandom_range(0, 3) != 0);
         s   = ($urandom_range(0, 4) == 0);
         op  = ($urandom_range(0, 9) < 8) ? 6'(8 + $urandom_range(0, 6)) : 6'($urandom_range(0, 63));
         xx  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 2)) : int'($urandom_range(0, 255));
         yy  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 2)) : int'($urandom_range(0, 255));
         off = int'($urandom_range(0, 255));
         step(v, s, op, xx, yy, off);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
